// File: rtl/puf_key_checker_if.sv
// Key-generator / AES-core side signals of the PUF key checker, bundled for port use.
// master drives the generator and AES-ready side; slave is the checker itself.
interface puf_key_checker_if #(
  parameter int KEY_W = 128
);
  logic [KEY_W-1:0] key_in;
  logic             key_enable;
  logic [KEY_W-1:0] ref_key;
  logic             aes_ready;
  logic [KEY_W-1:0] aes_key;
  logic             aes_key_valid;
  logic             key_fail;
  logic [7:0]       hd_count;
  logic             busy;

  modport master (
    output key_in, key_enable, ref_key, aes_ready,
    input  aes_key, aes_key_valid, key_fail, hd_count, busy
  );

  modport slave (
    input  key_in, key_enable, ref_key, aes_ready,
    output aes_key, aes_key_valid, key_fail, hd_count, busy
  );
endinterface

// File: rtl/puf_key_checker.sv
// Snapshots the PUF key, walks it MSB-slice first against the enrolled key summing
// the Hamming distance, then either hands the key to AES or raises a sticky failure.
module puf_key_checker #(
  parameter int KEY_W   = 128,
  parameter int SLICE_W = 16,
  parameter int HD_MAX  = 8
) (
  input logic               clk_divided,
  input logic               reset,
  puf_key_checker_if.slave  kif
);

  localparam int NUM_SLICES = KEY_W / SLICE_W;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int POP_W      = $clog2(SLICE_W + 1);
  localparam int HD_W       = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DECIDE, S_PASS, S_FAIL, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [KEY_W-1:0] snap_q, snap_d;
  logic [KEY_W-1:0] aes_key_q, aes_key_d;
  logic [HD_W-1:0]  hd_q, hd_d;
  logic             aes_valid_q, aes_valid_d;
  logic             fail_q, fail_d;
  logic             busy;

  function automatic logic [POP_W-1:0] popcnt(input logic [SLICE_W-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < SLICE_W; i++) cnt = cnt + POP_W'(v[i]);
    return cnt;
  endfunction

  // Packed slice views: element NUM_SLICES-1 is the MSB slice, i.e. slice index 0.
  logic [NUM_SLICES-1:0][SLICE_W-1:0] snap_sl, ref_sl;
  logic [NUM_SLICES-1:0][POP_W-1:0]   slice_pop;
  logic [POP_W-1:0]                   pop_sel;

  assign snap_sl = snap_q;
  assign ref_sl  = kif.ref_key;

  for (genvar g = 0; g < NUM_SLICES; g++) begin : g_slice
    assign slice_pop[g] = popcnt(snap_sl[g] ^ ref_sl[g]);
  end

  assign pop_sel = slice_pop[LAST_IDX - idx_q];

  // State register
  always_ff @(posedge clk_divided or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      snap_q      <= '0;
      aes_key_q   <= '0;
      hd_q        <= '0;
      aes_valid_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      aes_key_q   <= aes_key_d;
      hd_q        <= hd_d;
      aes_valid_q <= aes_valid_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    aes_key_d   = aes_key_q;
    hd_d        = hd_q;
    aes_valid_d = aes_valid_q;
    fail_d      = fail_q;
    unique case (state_q)
      S_IDLE: begin
        if (kif.key_enable) begin
          snap_d  = kif.key_in;
          idx_d   = '0;
          hd_d    = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Losing enable mid-walk discards the partial sum; a later enable restarts.
        if (!kif.key_enable) begin
          hd_d    = '0;
          state_d = S_IDLE;
        end else begin
          hd_d = hd_q + HD_W'(pop_sel);
          if (idx_q == LAST_IDX) state_d = S_DECIDE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_DECIDE: begin
        if (hd_q <= HD_W'(HD_MAX)) begin
          aes_key_d   = snap_q;
          aes_valid_d = 1'b1;
          state_d     = S_PASS;
        end else begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end
      end
      S_PASS: begin
        if (kif.aes_ready) begin
          aes_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_FAIL, S_DONE: ;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = 1'b0;
    if (state_q == S_CHECK || state_q == S_DECIDE) busy = 1'b1;
  end

  assign kif.aes_key       = aes_key_q;
  assign kif.aes_key_valid = aes_valid_q;
  assign kif.key_fail      = fail_q;
  assign kif.hd_count      = hd_q;
  assign kif.busy          = busy;

endmodule
